// File: rtl/regfile_param_if.sv
// rtl/regfile_param_if.sv - write/read port bundle for regfile_param
// master drives the write port and both read addresses; slave returns read data.
interface regfile_param_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b,
    input  rdata_a, rdata_b
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b,
    output rdata_a, rdata_b
  );
endinterface

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file, 1 write / 2 combinational read ports
// Optional hardwired zero register and optional same-cycle write-to-read bypass.
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic           clk,
  input  logic           clr,
  regfile_param_if.slave bus
);

  logic [WIDTH-1:0] words [DEPTH];
  logic [DEPTH-1:0] wen;
  logic             wr_live;
  logic [WIDTH-1:0] rdata_a_c;
  logic [WIDTH-1:0] rdata_b_c;

  // A write only counts when it will actually land: not under clear, not into r0 when hardwired.
  assign wr_live = bus.we && !clr && !((ZERO_REG != 0) && (bus.waddr == '0));

  always_comb begin
    wen = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wen[i] = wr_live && (bus.waddr == AW'(i));
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        words[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wen[i]) begin
          words[i] <= bus.wdata;
        end
      end
    end
  end

  always_comb begin
    rdata_a_c = words[bus.raddr_a];
    if ((BYPASS != 0) && wr_live && (bus.waddr == bus.raddr_a)) begin
      rdata_a_c = bus.wdata;
    end
    if ((ZERO_REG != 0) && (bus.raddr_a == '0)) begin
      rdata_a_c = '0;
    end
  end

  always_comb begin
    rdata_b_c = words[bus.raddr_b];
    if ((BYPASS != 0) && wr_live && (bus.waddr == bus.raddr_b)) begin
      rdata_b_c = bus.wdata;
    end
    if ((ZERO_REG != 0) && (bus.raddr_b == '0)) begin
      rdata_b_c = '0;
    end
  end

  assign bus.rdata_a = rdata_a_c;
  assign bus.rdata_b = rdata_b_c;

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - scoreboard bench for regfile_param
// Three instances: default (zero reg + bypass), plain storage (no zero reg, no bypass), 8x4 small.
module tb_regfile_param;

  logic clk = 1'b0;
  logic clr;

  always #10 clk = ~clk;

  regfile_param_if #(.WIDTH(32), .AW(5)) if_def ();
  regfile_param_if #(.WIDTH(32), .AW(5)) if_nb  ();
  regfile_param_if #(.WIDTH(8),  .AW(2)) if_sm  ();

  regfile_param #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(1), .BYPASS(1))
    u_def (.clk(clk), .clr(clr), .bus(if_def.slave));
  regfile_param #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(0), .BYPASS(0))
    u_nb  (.clk(clk), .clr(clr), .bus(if_nb.slave));
  regfile_param #(.WIDTH(8),  .DEPTH(4),  .AW(2), .ZERO_REG(0), .BYPASS(1))
    u_sm  (.clk(clk), .clr(clr), .bus(if_sm.slave));

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] m_def [32];
  logic [31:0] m_nb  [32];
  logic [7:0]  m_sm  [4];

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty: observed %h expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        mismatched++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [31:0] ex_def(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (if_def.we && !clr && if_def.waddr == a) return if_def.wdata;
    return m_def[a];
  endfunction

  function automatic logic [31:0] ex_nb(input logic [4:0] a);
    return m_nb[a];
  endfunction

  function automatic logic [31:0] ex_sm(input logic [1:0] a);
    if (if_sm.we && !clr && if_sm.waddr == a) return {24'h0, if_sm.wdata};
    return {24'h0, m_sm[a]};
  endfunction

  task automatic clear_models;
    for (int i = 0; i < 32; i++) begin
      m_def[i] = 32'h0;
      m_nb[i]  = 32'h0;
    end
    for (int i = 0; i < 4; i++) m_sm[i] = 8'h0;
  endtask

  task automatic idle_all;
    if_def.we = 1'b0; if_def.waddr = '0; if_def.wdata = '0; if_def.raddr_a = '0; if_def.raddr_b = '0;
    if_nb.we  = 1'b0; if_nb.waddr  = '0; if_nb.wdata  = '0; if_nb.raddr_a  = '0; if_nb.raddr_b  = '0;
    if_sm.we  = 1'b0; if_sm.waddr  = '0; if_sm.wdata  = '0; if_sm.raddr_a  = '0; if_sm.raddr_b  = '0;
  endtask

  // Advance one rising edge and commit the writes the bench drove into the reference model.
  task automatic step;
    @(posedge clk);
    if (!clr) begin
      if (if_def.we && if_def.waddr != 5'd0) m_def[if_def.waddr] = if_def.wdata;
      if (if_nb.we) m_nb[if_nb.waddr] = if_nb.wdata;
      if (if_sm.we) m_sm[if_sm.waddr] = if_sm.wdata;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    expect_val({tag, "_def_a"}, ex_def(if_def.raddr_a));
    expect_val({tag, "_def_b"}, ex_def(if_def.raddr_b));
    expect_val({tag, "_nb_a"},  ex_nb(if_nb.raddr_a));
    expect_val({tag, "_nb_b"},  ex_nb(if_nb.raddr_b));
    expect_val({tag, "_sm_a"},  ex_sm(if_sm.raddr_a));
    expect_val({tag, "_sm_b"},  ex_sm(if_sm.raddr_b));
    #1;
    compare(if_def.rdata_a);
    compare(if_def.rdata_b);
    compare(if_nb.rdata_a);
    compare(if_nb.rdata_b);
    compare({24'h0, if_sm.rdata_a});
    compare({24'h0, if_sm.rdata_b});
  endtask

  initial begin
    clr = 1'b1;
    idle_all();
    clear_models();
    #2;
    if_def.raddr_b = 5'd7;
    check_all("reset");
    step();
    clr = 1'b0;

    // r7 write, then asynchronous clear with no edge, then a write blocked by clear
    if_def.we = 1'b1; if_def.waddr = 5'd7; if_def.wdata = 32'hDEADBEEF;
    if_def.raddr_a = 5'd7; if_def.raddr_b = 5'd7;
    check_all("t1_bypass");
    step();
    if_def.we = 1'b0;
    expect_val("t1_r7_stored", 32'hDEADBEEF);
    #1;
    compare(if_def.rdata_a);
    #1;
    clr = 1'b1;
    clear_models();
    expect_val("t1_clr_async", 32'h0);
    #1;
    compare(if_def.rdata_a);
    step();
    if_def.we = 1'b1; if_def.waddr = 5'd7; if_def.wdata = 32'h12345678;
    check_all("t1_clr_write");
    step();
    clr = 1'b0;
    if_def.we = 1'b0;
    expect_val("t1_after_clr", 32'h0);
    #1;
    compare(if_def.rdata_a);

    // fill r1..r31 and sweep both ports
    for (int i = 1; i < 32; i++) begin
      if_def.we = 1'b1; if_def.waddr = 5'(i); if_def.wdata = 32'(i);
      step();
    end
    if_def.we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if_def.raddr_a = 5'(i);
      if_def.raddr_b = 5'(31 - i);
      expect_val("t2_sweep_a", 32'(i));
      expect_val("t2_sweep_b", (i == 31) ? 32'h0 : 32'(31 - i));
      #1;
      compare(if_def.rdata_a);
      compare(if_def.rdata_b);
    end

    // r0 write: discarded when hardwired, ordinary storage otherwise
    if_def.we = 1'b1; if_def.waddr = 5'd0; if_def.wdata = 32'hFFFFFFFF; if_def.raddr_a = 5'd0;
    if_nb.we  = 1'b1; if_nb.waddr  = 5'd0; if_nb.wdata  = 32'hFFFFFFFF; if_nb.raddr_a  = 5'd0;
    expect_val("t3_zero_same_cycle", 32'h0);
    expect_val("t3_nb_r0_before", 32'h0);
    #1;
    compare(if_def.rdata_a);
    compare(if_nb.rdata_a);
    step();
    if_def.we = 1'b0;
    if_nb.we  = 1'b0;
    expect_val("t3_zero_after", 32'h0);
    expect_val("t3_nb_r0_after", 32'hFFFFFFFF);
    #1;
    compare(if_def.rdata_a);
    compare(if_nb.rdata_a);

    // bypass vs. no bypass on r5, both ports at once
    if_def.we = 1'b1; if_def.waddr = 5'd5; if_def.wdata = 32'h11111111;
    if_nb.we  = 1'b1; if_nb.waddr  = 5'd5; if_nb.wdata  = 32'h11111111;
    step();
    if_def.wdata = 32'h22222222; if_def.raddr_a = 5'd5; if_def.raddr_b = 5'd5;
    if_nb.wdata  = 32'h22222222; if_nb.raddr_a  = 5'd5; if_nb.raddr_b  = 5'd5;
    expect_val("t4_byp_a", 32'h22222222);
    expect_val("t4_byp_b", 32'h22222222);
    expect_val("t4_nb_old_a", 32'h11111111);
    expect_val("t4_nb_old_b", 32'h11111111);
    #1;
    compare(if_def.rdata_a);
    compare(if_def.rdata_b);
    compare(if_nb.rdata_a);
    compare(if_nb.rdata_b);
    step();
    if_def.we = 1'b0;
    if_nb.we  = 1'b0;
    expect_val("t4_def_after_a", 32'h22222222);
    expect_val("t4_def_after_b", 32'h22222222);
    expect_val("t4_nb_after_a", 32'h22222222);
    expect_val("t4_nb_after_b", 32'h22222222);
    #1;
    compare(if_def.rdata_a);
    compare(if_def.rdata_b);
    compare(if_nb.rdata_a);
    compare(if_nb.rdata_b);
    if_def.we = 1'b1; if_def.waddr = 5'd6; if_def.wdata = 32'h33333333;
    if_def.raddr_a = 5'd6; if_def.raddr_b = 5'd7;
    expect_val("t4_port_a_only", 32'h33333333);
    expect_val("t4_port_b_unaffected", 32'h00000007);
    #1;
    compare(if_def.rdata_a);
    compare(if_def.rdata_b);
    step();
    if_def.we = 1'b0;

    // we=0 with random write address/data must leave everything untouched
    for (int n = 0; n < 50; n++) begin
      if_def.waddr = 5'($urandom_range(0, 31)); if_def.wdata = $urandom();
      if_nb.waddr  = 5'($urandom_range(0, 31)); if_nb.wdata  = $urandom();
      if_sm.waddr  = 2'($urandom_range(0, 3));  if_sm.wdata  = 8'($urandom());
      if_def.raddr_a = 5'($urandom_range(0, 31)); if_def.raddr_b = 5'($urandom_range(0, 31));
      if_nb.raddr_a  = 5'($urandom_range(0, 31)); if_nb.raddr_b  = 5'($urandom_range(0, 31));
      if_sm.raddr_a  = 2'($urandom_range(0, 3));  if_sm.raddr_b  = 2'($urandom_range(0, 3));
      check_all("t5_idle");
      step();
    end

    // small instance: 8-bit words, 4 entries, r0 is ordinary storage
    if_sm.we = 1'b1; if_sm.waddr = 2'd3; if_sm.wdata = 8'hA5;
    step();
    if_sm.waddr = 2'd0; if_sm.wdata = 8'h5A;
    step();
    if_sm.we = 1'b0; if_sm.raddr_a = 2'd3; if_sm.raddr_b = 2'd0;
    expect_val("t6_sm_r3", 32'h000000A5);
    expect_val("t6_sm_r0", 32'h0000005A);
    #1;
    compare({24'h0, if_sm.rdata_a});
    compare({24'h0, if_sm.rdata_b});
    if_sm.we = 1'b1; if_sm.waddr = 2'd1; if_sm.wdata = 8'h3C;
    if_sm.raddr_a = 2'd1; if_sm.raddr_b = 2'd3;
    check_all("t6_sm_bypass");
    step();
    if_sm.we = 1'b0;
    check_all("t6_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
